// File: rtl/scaled_fmt_encoder.sv
// Renormalises a wide signed Q.7 value onto the 16-bit {scale[2:0], mantissa[12:0]} bus.
// Latency k+2 cycles for k right-shifts (2..9); output held while out_ready is low, no input accepted until drained.
module scaled_fmt_encoder #(
  parameter int IN_W   = 24,
  parameter int ROUND  = 1,
  parameter int SAT_EN = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [15:0]     out_data,
  output logic            out_invalid,
  output logic            busy
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_ROUND, S_OUT} state_t;

  state_t            state_q, state_d;
  logic [IN_W-1:0]   acc_q, acc_d;
  logic [2:0]        scale_q, scale_d;
  logic              guard_q, guard_d;
  logic              ovf_q, ovf_d;
  logic              out_valid_q, out_valid_d;
  logic [15:0]       out_data_q, out_data_d;
  logic              out_invalid_q, out_invalid_d;

  logic [IN_W-1:0]   acc_hi;
  logic              fit;
  logic              rnd_bit;
  logic [13:0]       r;

  // acc fits the 13-bit mantissa when everything from bit 12 up is sign copies
  assign acc_hi  = IN_W'($signed(acc_q) >>> 12);
  assign fit     = (acc_hi == '0) || (acc_hi == '1);
  assign rnd_bit = (ROUND != 0) ? guard_q : 1'b0;
  assign r       = {acc_q[12], acc_q[12:0]} + {13'd0, rnd_bit};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      acc_q         <= '0;
      scale_q       <= '0;
      guard_q       <= 1'b0;
      ovf_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= 16'h0000;
      out_invalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      scale_q       <= scale_d;
      guard_q       <= guard_d;
      ovf_q         <= ovf_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_invalid_q <= out_invalid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    scale_d       = scale_q;
    guard_d       = guard_q;
    ovf_d         = ovf_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_invalid_d = out_invalid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          acc_d   = in_data;
          scale_d = 3'd7;
          guard_d = 1'b0;
          ovf_d   = 1'b0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (fit) begin
          state_d = S_ROUND;
        end else if (scale_q == 3'd0) begin
          ovf_d   = 1'b1;
          state_d = S_ROUND;
        end else begin
          acc_d   = IN_W'($signed(acc_q) >>> 1);
          guard_d = acc_q[0];
          scale_d = scale_q - 3'd1;
        end
      end
      S_ROUND: begin
        if (ovf_q) begin
          out_invalid_d = 1'b1;
          if (SAT_EN != 0)
            out_data_d = {3'd0, acc_q[IN_W-1] ? 13'h1000 : 13'h0FFF};
          else
            out_data_d = {3'd0, acc_q[12:0]};
        end else if (r == 14'd4096) begin
          // Round-up carried out of the mantissa: drop one scale step, which is exact
          if (scale_q != 3'd0) begin
            out_data_d    = {scale_q - 3'd1, 13'h0800};
            out_invalid_d = 1'b0;
          end else begin
            out_data_d    = {3'd0, 13'h0FFF};
            out_invalid_d = 1'b1;
          end
        end else begin
          out_data_d    = {scale_q, r[12:0]};
          out_invalid_d = 1'b0;
        end
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_invalid = out_invalid_q;

endmodule

// File: tb/tb_scaled_fmt_encoder.sv
// Directed bench: dut rounds and saturates, dut_t truncates and wraps on overflow.
module tb_scaled_fmt_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [23:0] in_data;
  logic        out_ready;
  logic        in_ready, out_valid, out_invalid, busy;
  logic [15:0] out_data;
  logic        in_ready_t, out_valid_t, out_invalid_t, busy_t;
  logic [15:0] out_data_t;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  scaled_fmt_encoder #(.IN_W(24), .ROUND(1), .SAT_EN(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_invalid(out_invalid), .busy(busy)
  );

  scaled_fmt_encoder #(.IN_W(24), .ROUND(0), .SAT_EN(0)) dut_t (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_t),
    .in_data(in_data), .out_valid(out_valid_t), .out_ready(out_ready),
    .out_data(out_data_t), .out_invalid(out_invalid_t), .busy(busy_t)
  );

  // Presents one value, returns edges from acceptance to out_valid (-1 on timeout)
  // and both instances' results, then lets the result drain with out_ready high.
  task automatic send(input logic [23:0] d, output int lat,
                      output logic [15:0] d1, output logic i1,
                      output logic [15:0] d2, output logic i2);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    d1 = out_data;   i1 = out_invalid;
    d2 = out_data_t; i2 = out_invalid_t;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_invalid !== 1'b0 || out_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b inv=%b data=%h, need 0 0 0000", out_valid, out_invalid, out_data);
    end
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: in_ready=%b busy=%b, need 1 0", in_ready, busy);
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_format();
    logic [23:0] vin [9]  = '{24'h000000, 24'h0000C0, 24'h001000, 24'h001FFF, 24'hFFEFFF,
                              24'h7FFFFF, 24'h800000, 24'hFFFFC0, 24'h07FFC0};
    logic [15:0] e1 [9]   = '{16'hE000, 16'hE0C0, 16'hC800, 16'hA800, 16'hD800,
                              16'h0FFF, 16'h1000, 16'hFFC0, 16'h0FFF};
    logic        ei1 [9]  = '{0, 0, 0, 0, 0, 1, 1, 0, 1};
    logic [15:0] e2 [9]   = '{16'hE000, 16'hE0C0, 16'hC800, 16'hCFFF, 16'hD7FF,
                              16'h1FFF, 16'h0000, 16'hFFC0, 16'h0FFF};
    logic        ei2 [9]  = '{0, 0, 0, 0, 0, 1, 1, 0, 0};
    int          elat [9] = '{2, 2, 3, 3, 3, 9, 9, 2, 9};
    int          lat;
    logic [15:0] d1, d2;
    logic        i1, i2;
    for (int v = 0; v < 9; v++) begin
      send(vin[v], lat, d1, i1, d2, i2);
      n_checks++;
      if (lat !== elat[v]) begin
        n_fail++;
        $display("FAIL latency[%h]: got %0d cycles, need %0d", vin[v], lat, elat[v]);
      end
      n_checks++;
      if (d1 !== e1[v] || i1 !== ei1[v]) begin
        n_fail++;
        $display("FAIL round_sat[%h]: got %h inv=%b, need %h inv=%b", vin[v], d1, i1, e1[v], ei1[v]);
      end
      n_checks++;
      if (d2 !== e2[v] || i2 !== ei2[v]) begin
        n_fail++;
        $display("FAIL trunc_wrap[%h]: got %h inv=%b, need %h inv=%b", vin[v], d2, i2, e2[v], ei2[v]);
      end
    end
  endtask

  task automatic test_backpressure();
    int w;
    out_ready = 1'b0;
    in_data   = 24'h0000C0;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    // A second offer while busy must not be consumed
    in_data = 24'h001000;
    w = 0;
    while (!out_valid && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 16'hE0C0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold[%0d]: valid=%b data=%h in_ready=%b, need 1 E0C0 0", c, out_valid, out_data, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL drain: valid=%b in_ready=%b, need 0 1", out_valid, in_ready);
    end
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_input_ignored: valid=%b busy=%b, need 0 0", out_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] vin [2] = '{24'h000000, 24'h001000};
    int          ecyc [2] = '{4, 5};
    int          cnt;
    for (int v = 0; v < 2; v++) begin
      in_data  = vin[v];
      in_valid = 1'b1;
      @(posedge clk); #1;
      cnt = 1;
      while (!in_ready && cnt < 30) begin
        @(posedge clk); #1;
        cnt++;
      end
      in_valid = 1'b0;
      n_checks++;
      if (cnt !== ecyc[v]) begin
        n_fail++;
        $display("FAIL throughput[%h]: got %0d cycles per result, need %0d", vin[v], cnt, ecyc[v]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_shift();
    int          lat;
    logic [15:0] d1, d2;
    logic        i1, i2;
    logic        seen;
    in_data  = 24'h7FFFFF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_mid_shift: valid=%b in_ready=%b busy=%b data=%h, need 0 1 0 0000",
               out_valid, in_ready, busy, out_data);
    end
    reset = 1'b1;
    seen  = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL dropped_op: out_valid seen=%b, need 0", seen);
    end
    send(24'h0000C0, lat, d1, i1, d2, i2);
    n_checks++;
    if (lat !== 2 || d1 !== 16'hE0C0 || i1 !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset: lat=%0d data=%h inv=%b, need 2 E0C0 0", lat, d1, i1);
    end
  endtask

  initial begin
    test_reset();
    test_format();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_shift();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
